// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
//   Shared definitions for the ADC triggered capture buffer and the GPIO
//   readback block that reports its status.
//   - cap_state_t : capture FSM state, encoding visible on the state port
//   - DATA_W_DEF  : default ADC word width
//   - GPIO_REG_*  : status register addresses used by the GPIO readback block
package adc_capture_pkg;

   localparam int unsigned DATA_W_DEF = 128;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_ARMED   = 2'd1,
      CAP_CAPTURE = 2'd2,
      CAP_DONE    = 2'd3
   } cap_state_t;

   localparam logic [7:0] GPIO_REG_STATE    = 8'h00;
   localparam logic [7:0] GPIO_REG_FILL     = 8'h04;
   localparam logic [7:0] GPIO_REG_DONE     = 8'h08;
   localparam logic [7:0] GPIO_REG_OVERFLOW = 8'h0C;
   localparam logic [7:0] GPIO_REG_DROP_CNT = 8'h10;

   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo
//   Synchronous first-word-fall-through RAM FIFO.
//   Ports:
//     clk, rst (async, active-low)
//     clr          synchronous clear; discards any push/pop in the same cycle
//     push, wdata  write request; accepted when not full or when popping
//     pop          read request; ignored while empty
//     rdata        head word, zero while empty
//     full, empty  occupancy flags
//     fill         current occupancy (0..DEPTH)
//   DEPTH must be a power of two, at least 2.
module adc_capture_fifo
   import adc_capture_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   always_comb begin
      empty    = (fill_q == '0);
      // DEPTH is a power of two, so the MSB of fill alone marks "full"
      full     = fill_q[PTR_W];
      do_pop   = pop && !empty && !clr;
      do_push  = push && (!full || do_pop) && !clr;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
         endcase
      end

      // Gate the head word so m_data reads zero whenever nothing is held
      rdata = empty ? '0 : mem_q[rd_ptr_q];
      fill  = fill_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Storage array is deliberately not reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
//   Triggered capture buffer for one 128-bit ADC sample stream. After arm it
//   waits for trig, captures cap_len ADC beats into a FWFT FIFO and holds them
//   for CPU readback through the m_* valid/ready port.
//   Ports:
//     clk, rst (async, active-low)
//     arm, cap_len       arm request and capture length (latched on accept)
//     trig               capture trigger, sampled while ARMED
//     flush              synchronous clear of FIFO, flags and FSM
//     s_data, s_valid    ADC stream, no backpressure
//     m_data, m_valid, m_ready   readback stream (FWFT)
//     state, fill, done, overflow   capture status
//   Build option:
//     ADC_CAPTURE_DROP_CNT_EN  adds drop_cnt[15:0], a saturating count of
//                              beats dropped because the FIFO was full
module adc_capture_buffer
   import adc_capture_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned LEN_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arm,
   input  logic                   trig,
   input  logic                   flush,
   input  logic [LEN_W-1:0]       cap_len,
   input  logic [DATA_W-1:0]      s_data,
   input  logic                   s_valid,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   done,
   output logic                   overflow
`ifdef ADC_CAPTURE_DROP_CNT_EN
   ,
   output logic [15:0]            drop_cnt
`endif
);

   cap_state_t        state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_inc;
   logic              ovf_q, ovf_d;
   logic              cap_beat;
   logic              beat_drop;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              arm_ok;
`ifdef ADC_CAPTURE_DROP_CNT_EN
   logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      ovf_d    = ovf_q;
      cap_beat = 1'b0;
      cnt_inc  = cnt_q + LEN_W'(1);
      arm_ok   = arm && (cap_len != '0);
      fifo_pop = m_ready && !fifo_empty;

      case (state_q)
         CAP_IDLE: begin
            if (arm_ok) begin
               len_d   = cap_len;
               state_d = CAP_ARMED;
            end
         end
         CAP_ARMED: begin
            if (trig && s_valid) begin
               cap_beat = 1'b1;
               cnt_d    = LEN_W'(1);
               state_d  = (len_q == LEN_W'(1)) ? CAP_DONE : CAP_CAPTURE;
            end
         end
         CAP_CAPTURE: begin
            // Every ADC beat advances the window, stored or dropped
            if (s_valid) begin
               cap_beat = 1'b1;
               cnt_d    = cnt_inc;
               if (cnt_inc == len_q) state_d = CAP_DONE;
            end
         end
         CAP_DONE: begin
            // Re-arm keeps FIFO contents; the next capture appends
            if (arm_ok) begin
               len_d   = cap_len;
               cnt_d   = '0;
               state_d = CAP_ARMED;
            end
         end
      endcase

      // A same-cycle pop frees a slot, so a full FIFO can still take the beat
      beat_drop = cap_beat && fifo_full && !fifo_pop;
      fifo_push = cap_beat && !beat_drop;
      if (beat_drop) ovf_d = 1'b1;

`ifdef ADC_CAPTURE_DROP_CNT_EN
      drop_cnt_d = drop_cnt_q;
      if (beat_drop && (drop_cnt_q != DROP_CNT_MAX))
         drop_cnt_d = drop_cnt_q + 16'd1;
`endif

      if (flush) begin
         state_d   = CAP_IDLE;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         fifo_push = 1'b0;
`ifdef ADC_CAPTURE_DROP_CNT_EN
         drop_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CAP_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef ADC_CAPTURE_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_cnt_q <= '0;
      else      drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

   adc_capture_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (fifo_push),
      .wdata (s_data),
      .pop   (fifo_pop),
      .rdata (m_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .fill  (fill)
   );

   always_comb begin
      m_valid  = !fifo_empty;
      state    = state_q;
      done     = (state_q == CAP_DONE);
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer
//   Bench for adc_capture_buffer built with DEPTH=4. Per-cycle vector table
//   with expected status, plus a queue of expected readback words.
//   Honours ADC_CAPTURE_DROP_CNT_EN when defined.
module tb_adc_capture_buffer;
   import adc_capture_pkg::*;

   localparam int unsigned DW    = 128;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          arm = 1'b0;
   logic          trig = 1'b0;
   logic          flush = 1'b0;
   logic [LW-1:0] cap_len = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [1:0]    state;
   logic [2:0]    fill;
   logic          done;
   logic          overflow;
`ifdef ADC_CAPTURE_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   adc_capture_buffer #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .LEN_W  (LW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .trig     (trig),
      .flush    (flush),
      .cap_len  (cap_len),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .state    (state),
      .fill     (fill),
      .done     (done),
      .overflow (overflow)
`ifdef ADC_CAPTURE_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   typedef struct {
      logic        arm;
      logic        trig;
      logic        flush;
      logic [15:0] len;
      logic        sv;
      logic [7:0]  d;
      logic        mr;
      logic        store;
      logic [1:0]  st;
      logic [2:0]  fill;
      logic        done;
      logic        ovf;
      logic [15:0] drop;
   } vec_t;

   vec_t          tbl[$];
   logic [DW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;

   function automatic vec_t v(input logic a, input logic t, input logic f,
                              input logic [15:0] l, input logic sv,
                              input logic [7:0] d, input logic mr,
                              input logic sto, input logic [1:0] st,
                              input logic [2:0] fl, input logic dn,
                              input logic ov, input logic [15:0] dr);
      vec_t r;
      r.arm = a; r.trig = t; r.flush = f; r.len = l; r.sv = sv; r.d = d;
      r.mr = mr; r.store = sto; r.st = st; r.fill = fl; r.done = dn;
      r.ovf = ov; r.drop = dr;
      return r;
   endfunction

   function automatic logic [DW-1:0] word(input logic [7:0] d);
      return {16{d}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      arm = 1'b0; trig = 1'b0; flush = 1'b0; cap_len = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " state"},    DW'(state),    '0);
      chk({tag, " fill"},     DW'(fill),     '0);
      chk({tag, " m_valid"},  DW'(m_valid),  '0);
      chk({tag, " m_data"},   m_data,        '0);
      chk({tag, " done"},     DW'(done),     '0);
      chk({tag, " overflow"}, DW'(overflow), '0);
`ifdef ADC_CAPTURE_DROP_CNT_EN
      chk({tag, " drop_cnt"}, DW'(drop_cnt), '0);
`endif
   endtask

   initial begin
      // Test 1: arm len 4, trig on third beat of 0..9, then drain
      tbl.push_back(v(1,0,0,4, 0,8'h00,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h00,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h01,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h02,0,1, 2,1,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h03,0,1, 2,2,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h04,0,1, 2,3,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h05,0,1, 3,4,1,0,0));
      for (int k = 6; k < 10; k++)
         tbl.push_back(v(0,1,0,0, 1,8'(k),0,0, 3,4,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,3,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,2,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,1,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,0,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,0,1,0,0));
      // Test 2: len 6 into DEPTH 4 with no reads: two dropped
      tbl.push_back(v(0,0,1,0, 0,8'h00,0,0, 0,0,0,0,0));
      tbl.push_back(v(1,0,0,6, 0,8'h00,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h10,0,1, 2,1,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h11,0,1, 2,2,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h12,0,1, 2,3,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h13,0,1, 2,4,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h14,0,0, 2,4,0,1,1));
      tbl.push_back(v(0,0,0,0, 1,8'h15,0,0, 3,4,1,1,2));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,3,1,1,2));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,2,1,1,2));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,1,1,1,2));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,0,1,1,2));
      // Test 3: full FIFO, capture beat and pop together
      tbl.push_back(v(0,0,1,0, 0,8'h00,0,0, 0,0,0,0,0));
      tbl.push_back(v(1,0,0,5, 0,8'h00,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h20,0,1, 2,1,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h21,0,1, 2,2,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h22,0,1, 2,3,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h23,0,1, 2,4,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h24,1,1, 3,4,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,3,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,2,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,1,1,0,0));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 3,0,1,0,0));
      // Test 4: arm with length zero is ignored
      tbl.push_back(v(0,0,1,0, 0,8'h00,0,0, 0,0,0,0,0));
      tbl.push_back(v(1,0,0,0, 0,8'h00,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h30,0,0, 0,0,0,0,0));
      // Test 5: flush mid-capture with fill 3 and overflow set
      tbl.push_back(v(1,0,0,10,0,8'h00,0,0, 1,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h40,0,1, 2,1,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h41,0,1, 2,2,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h42,0,1, 2,3,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h43,0,1, 2,4,0,0,0));
      tbl.push_back(v(0,0,0,0, 1,8'h44,0,0, 2,4,0,1,1));
      tbl.push_back(v(0,0,0,0, 0,8'h00,1,0, 2,3,0,1,1));
      tbl.push_back(v(0,0,1,0, 1,8'h45,1,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,0,0, 1,8'h46,0,0, 0,0,0,0,0));

      // Reset state
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-release state", DW'(state), DW'(CAP_IDLE));

      // Vector table
      foreach (tbl[i]) begin
         arm     = tbl[i].arm;
         trig    = tbl[i].trig;
         flush   = tbl[i].flush;
         cap_len = tbl[i].len;
         s_valid = tbl[i].sv;
         s_data  = word(tbl[i].d);
         m_ready = tbl[i].mr;
         if (tbl[i].flush) begin
            exp_q.delete();
         end else if (tbl[i].mr) begin
            if (exp_q.size() > 0)
               chk($sformatf("row%0d m_data", i), m_data, exp_q.pop_front());
            else
               chk($sformatf("row%0d m_valid empty", i), DW'(m_valid), '0);
         end
         if (tbl[i].store) exp_q.push_back(word(tbl[i].d));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d state", i),    DW'(state),    DW'(tbl[i].st));
         chk($sformatf("row%0d fill", i),     DW'(fill),     DW'(tbl[i].fill));
         chk($sformatf("row%0d done", i),     DW'(done),     DW'(tbl[i].done));
         chk($sformatf("row%0d overflow", i), DW'(overflow), DW'(tbl[i].ovf));
         chk($sformatf("row%0d m_valid", i),  DW'(m_valid),  DW'(tbl[i].fill != 3'd0));
`ifdef ADC_CAPTURE_DROP_CNT_EN
         chk($sformatf("row%0d drop_cnt", i), DW'(drop_cnt), DW'(tbl[i].drop));
`endif
      end

      // Test 6: asynchronous reset in the middle of a capture
      idle_inputs();
      exp_q.delete();
      arm = 1'b1; cap_len = 16'd8;
      @(posedge clk); #1;
      arm = 1'b0; cap_len = '0;
      trig = 1'b1; s_valid = 1'b1; s_data = word(8'h50);
      @(posedge clk); #1;
      trig = 1'b0; s_data = word(8'h51);
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("async pre state", DW'(state), DW'(CAP_CAPTURE));
      chk("async pre fill",  DW'(fill),  DW'(3'd2));
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("async release state", DW'(state), DW'(CAP_IDLE));
      chk("async release fill",  DW'(fill),  '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
